// File: rtl/scaled_tick_timer_if.sv
// Signal bundle between the clock-scaler consumer (scaled_tick_timer) and its controller.
// The master drives the stimulus and load value; the slave returns tick, count and status.
interface scaled_tick_timer_if #(
  parameter int WIDTH = 8
);
  logic             scaled_clk;
  logic             start;
  logic             pause;
  logic [WIDTH-1:0] load_val;
  logic             tick_out;
  logic [WIDTH-1:0] count;
  logic             running;
  logic             expired;
  logic             done;

  modport master (
    output scaled_clk, start, pause, load_val,
    input  tick_out, count, running, expired, done
  );

  modport slave (
    input  scaled_clk, start, pause, load_val,
    output tick_out, count, running, expired, done
  );
endinterface

// File: rtl/scaled_tick_timer.sv
// Countdown timer stepped by rising edges of a divided clock that is sampled as data.
// state | meaning
// IDLE  | after reset, count held, waiting for start
// RUN   | count decrements on each tick
// PAUSE | count held, ticks ignored until pause drops
// DONE  | count reached 0, expired asserted until restart
module scaled_tick_timer #(
  parameter int WIDTH = 8
) (
  input logic                 clk,
  input logic                 reset,
  scaled_tick_timer_if.slave  tmr
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] count_r, count_nxt;
  logic             done_r, done_nxt;
  logic             scaled_q;
  logic             tick_r;
  logic             running_c, expired_c;

  // Edge detector: scaled_clk is only ever treated as a level in the clk domain.
  always_ff @(posedge clk) begin
    if (!reset) begin
      scaled_q <= 1'b0;
      tick_r   <= 1'b0;
    end else begin
      scaled_q <= tmr.scaled_clk;
      tick_r   <= tmr.scaled_clk & ~scaled_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      count_r <= '0;
      done_r  <= 1'b0;
    end else begin
      state   <= state_nxt;
      count_r <= count_nxt;
      done_r  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count_r;
    done_nxt  = 1'b0;
    // A start in any state reloads; a zero load goes straight to DONE.
    if (tmr.start) begin
      if (tmr.load_val != '0) begin
        state_nxt = RUN;
        count_nxt = tmr.load_val;
      end else begin
        state_nxt = DONE;
        count_nxt = '0;
        done_nxt  = 1'b1;
      end
    end else begin
      case (state)
        RUN: begin
          if (tmr.pause) begin
            state_nxt = PAUSE;
          end else if (tick_r) begin
            if (count_r <= WIDTH'(1)) begin
              state_nxt = DONE;
              count_nxt = '0;
              done_nxt  = 1'b1;
            end else begin
              count_nxt = count_r - WIDTH'(1);
            end
          end
        end
        PAUSE: begin
          if (!tmr.pause) state_nxt = RUN;
        end
        DONE: begin
          count_nxt = '0;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  always_comb begin
    running_c = (state == RUN);
    expired_c = (state == DONE);
  end

  assign tmr.tick_out = tick_r;
  assign tmr.count    = count_r;
  assign tmr.running  = running_c;
  assign tmr.expired  = expired_c;
  assign tmr.done     = done_r;

endmodule

// File: doc/scaled_tick_timer.md
Name: scaled_tick_timer

Overview:
- Downstream consumer of the divided clock from the clock scaler. Samples scaled_clk as a level in the system clk domain and detects its rising edges to form a one-cycle tick strobe.
- Runs a loadable countdown timer that decrements once per tick, with start, restart, pause and expiry signalling.
- Feeds display/game-control logic with the remaining count and the timer status.

Parameters:
- WIDTH, 8, width of load_val and count.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset).
- scaled_clk  input  1  divided clock from the clock scaler, treated as data.
- start  input  1  load load_val and run; level-sampled each clk.
- pause  input  1  hold the count while 1 (RUN/PAUSE only).
- load_val  input  WIDTH  countdown start value.
- tick_out  output  1  registered one-cycle strobe on each scaled_clk rising edge.
- count  output  WIDTH  remaining count.
- running  output  1  1 while state == RUN.
- expired  output  1  1 while state == DONE.
- done  output  1  one-cycle pulse on entry to DONE.

Behaviour:
- Reset (reset == 0 at a clk edge) forces: scaled_q = 0, tick_out = 0, state = IDLE, count = 0, done = 0. Reset has priority over every other input, including mid-countdown.
- Edge detect:
  - scaled_q <= scaled_clk every cycle.
  - tick_out <= scaled_clk & ~scaled_q.
  - A rise sampled at edge k gives tick_out = 1 for exactly the cycle after edge k.
  - scaled_clk held high gives no further ticks.
- The FSM acts on tick_out, so a decrement lands at edge k+1.
- running and expired decode state combinationally. done is registered.
- Priority within a cycle: reset > start > pause > tick.
- IDLE:
  - count holds.
  - start = 1 and load_val != 0: count <= load_val, go to RUN.
  - start = 1 and load_val == 0: count <= 0, go to DONE, done pulses.
- RUN:
  - start = 1: reload count from load_val and stay in RUN, or go to DONE if load_val == 0. Any tick in that cycle is ignored.
  - else pause = 1: go to PAUSE. A coincident tick is dropped and count does not change.
  - else tick_out = 1 and count == 1: count <= 0, go to DONE, done <= 1.
  - else tick_out = 1: count <= count - 1.
- PAUSE:
  - count holds and ticks are ignored.
  - start = 1: reload as in RUN.
  - else pause = 0: return to RUN. Counting resumes on the next tick; no catch-up for missed ticks.
- DONE:
  - count stays 0 and expired = 1.
  - start = 1: reload as in IDLE.
  - pause is ignored.
- done rules:
  - done = 1 only in the cycle after the transition into DONE; otherwise 0.
  - A start in DONE that reloads 0 re-enters DONE and pulses done again.
- count never wraps. Decrement happens only when count >= 2 in RUN; count == 1 goes to 0 and DONE.
- With start held high, the block reloads every cycle and count never decrements. Start is level-based; upstream provides a pulse.
- Deasserting reset resumes from IDLE with scaled_q = 0. If scaled_clk is already 1 at that point, one tick_out fires, which is harmless in IDLE.

Test Plan:
- Reset: hold reset = 0 for 3 cycles with scaled_clk toggling -> count = 0, tick_out = 0, done = 0, running = 0, expired = 0.
- Edge detect: scaled_clk low 5 cycles, high 4, low 3 -> exactly one tick_out pulse, in the cycle after the first high sample.
- Countdown: load_val = 3, start for 1 cycle, then 3 scaled_clk rises ->
  - count goes 3, 2, 1, 0.
  - done is high one cycle after the cycle where tick_out and count == 1 coincide.
  - expired stays 1 and running = 0 afterwards.
- Pause:
  - load_val = 5; after 2 ticks (count = 3), assert pause across 2 scaled_clk rises -> count stays 3 and state = PAUSE.
  - Release pause -> next tick gives count = 2.
  - A pause coinciding with a tick -> count unchanged.
- Restart/zero:
  - start with load_val = 9 while in RUN at count = 4 -> count = 9 next cycle, still RUN.
  - start with load_val = 0 from IDLE -> DONE with one done pulse, no tick required.
- Mid-run reset: load_val = 6, after 2 ticks drive reset = 0 for 1 cycle -> IDLE, count = 0, no done pulse.
